// File: rtl/seq_comparator_32b.sv
// seq_comparator_32b: multi-cycle 32-bit magnitude comparator, one nibble
// per clock from the MSB down, stopping at the first differing nibble.
//
// Optional feature macro: SEQ_COMP_SIGNED_EN
//   When defined, adds the i_signed port. With captured i_signed=1, the
//   top nibble treats bit 31 as a two's-complement sign bit.
//
// Ports:
//   i_clk      clock, all state on rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    request, accepted only when o_busy=0 (IDLE or DONE)
//   i_a, i_b   32-bit operands, captured on accepted start
//   i_bg/i_sl/i_eq  cascade inputs, used when all nibbles are equal
//   i_signed   signed compare select (SEQ_COMP_SIGNED_EN only)
//   o_busy     comparison in progress
//   o_done     one-cycle pulse when result flags update
//   o_bg/o_sl/o_eq  A>B, A<B, A=B (held until the next result)
module seq_comparator_32b (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_bg,
    input  logic        i_sl,
    input  logic        i_eq,
`ifdef SEQ_COMP_SIGNED_EN
    input  logic        i_signed,
`endif
    output logic        o_busy,
    output logic        o_done,
    output logic        o_bg,
    output logic        o_sl,
    output logic        o_eq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [31:0] a_cap;
    logic [31:0] a_cap_next;
    logic [31:0] b_cap;
    logic [31:0] b_cap_next;
    logic [2:0]  casc;
    logic [2:0]  casc_next;
    logic        busy_next;
    logic        done_next;
    logic        bg_next;
    logic        sl_next;
    logic        eq_next;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic        accept;

`ifdef SEQ_COMP_SIGNED_EN
    logic        sgn;
    logic        sgn_next;
`endif

    // Current nibble pair under comparison.
    always_comb begin
        a_nib = a_cap[{idx, 2'b00} +: 4];
        b_nib = b_cap[{idx, 2'b00} +: 4];
`ifdef SEQ_COMP_SIGNED_EN
        // Flipping both sign bits maps two's-complement order onto
        // unsigned order for the top nibble.
        if (sgn && (idx == 3'd7)) begin
            a_nib[3] = ~a_nib[3];
            b_nib[3] = ~b_nib[3];
        end
`endif
    end

    // A new start is taken whenever no comparison is running.
    assign accept = i_start && (state != RUN);

    always_comb begin
        state_next = state;
        idx_next   = idx;
        a_cap_next = a_cap;
        b_cap_next = b_cap;
        casc_next  = casc;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        bg_next    = o_bg;
        sl_next    = o_sl;
        eq_next    = o_eq;
`ifdef SEQ_COMP_SIGNED_EN
        sgn_next   = sgn;
`endif

        unique case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    state_next = RUN;
                    idx_next   = 3'd7;
                    a_cap_next = i_a;
                    b_cap_next = i_b;
                    casc_next  = {i_bg, i_sl, i_eq};
                    busy_next  = 1'b1;
`ifdef SEQ_COMP_SIGNED_EN
                    sgn_next   = i_signed;
`endif
                end
            end
            RUN: begin
                busy_next = 1'b1;
                if (a_nib > b_nib) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    {bg_next, sl_next, eq_next} = 3'b100;
                end else if (a_nib < b_nib) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    {bg_next, sl_next, eq_next} = 3'b010;
                end else if (idx != 3'd0) begin
                    idx_next = idx - 3'd1;
                end else begin
                    // All nibbles equal: cascade bits pass straight through.
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    {bg_next, sl_next, eq_next} = casc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            idx    <= 3'd7;
            a_cap  <= 32'd0;
            b_cap  <= 32'd0;
            casc   <= 3'd0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_bg   <= 1'b0;
            o_sl   <= 1'b0;
            o_eq   <= 1'b0;
`ifdef SEQ_COMP_SIGNED_EN
            sgn    <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            a_cap  <= a_cap_next;
            b_cap  <= b_cap_next;
            casc   <= casc_next;
            o_busy <= busy_next;
            o_done <= done_next;
            o_bg   <= bg_next;
            o_sl   <= sl_next;
            o_eq   <= eq_next;
`ifdef SEQ_COMP_SIGNED_EN
            sgn    <= sgn_next;
`endif
        end
    end

endmodule

// File: tb/tb_seq_comparator_32b.sv
// tb_seq_comparator_32b: directed self-checking bench for seq_comparator_32b.
// Signed cases are included when SEQ_COMP_SIGNED_EN is defined.
module tb_seq_comparator_32b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bg_in;
    logic        sl_in;
    logic        eq_in;
    logic        busy;
    logic        done;
    logic        bg;
    logic        sl;
    logic        eq;
`ifdef SEQ_COMP_SIGNED_EN
    logic        sgn;
`endif

    int checks;
    int errors;

    seq_comparator_32b dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_a      (a),
        .i_b      (b),
        .i_bg     (bg_in),
        .i_sl     (sl_in),
        .i_eq     (eq_in),
`ifdef SEQ_COMP_SIGNED_EN
        .i_signed (sgn),
`endif
        .o_busy   (busy),
        .o_done   (done),
        .o_bg     (bg),
        .o_sl     (sl),
        .o_eq     (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start and wait for o_done. cycles counts sampled cycles
    // from after the accepting edge up to the o_done cycle (-1 on timeout).
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic [2:0] vc,
                          output int cycles, output int busy_cycles);
        @(negedge clk);
        a = va;
        b = vb;
        {bg_in, sl_in, eq_in} = vc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = -1;
        busy_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        {bg_in, sl_in, eq_in} = 3'b000;
`ifdef SEQ_COMP_SIGNED_EN
        sgn = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, bg, sl, eq} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {busy, done, bg, sl, eq});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_msb_diff();
        int cyc;
        int bcyc;
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b001, cyc, bcyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL msb_latency: got %0d want 2", cyc);
        end
        checks++;
        if (bcyc !== 1) begin
            errors++;
            $display("FAIL msb_busy_cycles: got %0d want 1", bcyc);
        end
        checks++;
        if ({bg, sl, eq} !== 3'b100) begin
            errors++;
            $display("FAIL msb_flags: got %b want 100", {bg, sl, eq});
        end
        @(negedge clk);
        checks++;
        if ({busy, done, bg, sl, eq} !== 5'b00100) begin
            errors++;
            $display("FAIL msb_after_done: got %b want 00100",
                     {busy, done, bg, sl, eq});
        end
    endtask

    task automatic test_lsb_diff();
        int cyc;
        int bcyc;
        run_op(32'h1234_5670, 32'h1234_5671, 3'b001, cyc, bcyc);
        checks++;
        if (cyc !== 9 || bcyc !== 8) begin
            errors++;
            $display("FAIL lsb_latency: got %0d/%0d want 9/8", cyc, bcyc);
        end
        checks++;
        if ({bg, sl, eq} !== 3'b010) begin
            errors++;
            $display("FAIL lsb_flags: got %b want 010", {bg, sl, eq});
        end
    endtask

    task automatic test_equal_cascade();
        int cyc;
        int bcyc;
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b100, cyc, bcyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL eq_latency: got %0d want 9", cyc);
        end
        checks++;
        if ({bg, sl, eq} !== 3'b100) begin
            errors++;
            $display("FAIL eq_casc100: got %b want 100", {bg, sl, eq});
        end
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001, cyc, bcyc);
        checks++;
        if (cyc !== 9 || {bg, sl, eq} !== 3'b001) begin
            errors++;
            $display("FAIL eq_casc001: got %0d/%b want 9/001",
                     cyc, {bg, sl, eq});
        end
        run_op(32'h0000_0000, 32'h0000_0000, 3'b110, cyc, bcyc);
        checks++;
        if (cyc !== 9 || {bg, sl, eq} !== 3'b110) begin
            errors++;
            $display("FAIL eq_casc110: got %0d/%b want 9/110",
                     cyc, {bg, sl, eq});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bcyc;
        int bad_hold;
        run_op(32'hF000_0000, 32'h0000_0000, 3'b000, cyc, bcyc);
        checks++;
        if (cyc !== 2 || {bg, sl, eq} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_first: got %0d/%b want 2/100",
                     cyc, {bg, sl, eq});
        end
        // Still in the DONE cycle: start the next one now.
        a = 32'h0000_0000;
        b = 32'h0000_0001;
        {bg_in, sl_in, eq_in} = 3'b000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        bad_hold = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
            if ({bg, sl, eq} !== 3'b100) bad_hold++;
            if (k == 3) begin
                a = 32'd5;
                b = 32'd5;
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        checks++;
        if (bad_hold !== 0) begin
            errors++;
            $display("FAIL b2b_hold: got %0d bad cycles want 0", bad_hold);
        end
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want 9", cyc);
        end
        checks++;
        if ({bg, sl, eq} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_second: got %b want 010", {bg, sl, eq});
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_ignored_start: got %b want 00",
                     {busy, done});
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int bcyc;
        int seen_done;
        @(negedge clk);
        a = 32'h0000_0001;
        b = 32'h0000_0002;
        {bg_in, sl_in, eq_in} = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, bg, sl, eq} !== 5'b00000) begin
            errors++;
            $display("FAIL midrun_reset: got %b want 00000",
                     {busy, done, bg, sl, eq});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d active cycles want 0",
                     seen_done);
        end
        run_op(32'h0000_0001, 32'h0000_0002, 3'b001, cyc, bcyc);
        checks++;
        if (cyc !== 9 || {bg, sl, eq} !== 3'b010) begin
            errors++;
            $display("FAIL midrun_restart: got %0d/%b want 9/010",
                     cyc, {bg, sl, eq});
        end
    endtask

`ifdef SEQ_COMP_SIGNED_EN
    task automatic test_signed();
        int cyc;
        int bcyc;
        sgn = 1'b1;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b001, cyc, bcyc);
        checks++;
        if (cyc !== 2 || {bg, sl, eq} !== 3'b010) begin
            errors++;
            $display("FAIL signed_on: got %0d/%b want 2/010",
                     cyc, {bg, sl, eq});
        end
        sgn = 1'b0;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b001, cyc, bcyc);
        checks++;
        if (cyc !== 2 || {bg, sl, eq} !== 3'b100) begin
            errors++;
            $display("FAIL signed_off: got %0d/%b want 2/100",
                     cyc, {bg, sl, eq});
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_msb_diff();
        test_lsb_diff();
        test_equal_cascade();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SEQ_COMP_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
